// File: rtl/weight_update_stage.sv
// weight_update_stage: serial SGD weight update.
// Latches one scaled gradient, then walks the feature vector one element per
// accepted beat applying w[i] <= sat(w[i] - sat((grad * x[i]) >>> fracBits)).
// Provides a registered read port for the forward path and a load port for
// weight initialisation.
//
// state  | meaning
// IDLE   | waiting for a gradient; weight loads honoured here
// UPDATE | consuming feature beats, one weight updated per beat
// DONE   | single-cycle completion, done pulse and sample counter bump
module weight_update_stage #(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16,
  parameter int DEPTH         = 8,
  parameter int fracBits      = 8,
  parameter int addrBits      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [bitwidth-1:0]      grad,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic [inputBitwidth-1:0] x_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     w_ld_en,
  input  logic [addrBits-1:0]      w_ld_addr,
  input  logic [bitwidth-1:0]      w_ld_data,
  input  logic [addrBits-1:0]      w_rd_addr,
  output logic [bitwidth-1:0]      w_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              sample_cnt
);

  localparam int PW = bitwidth + inputBitwidth;
  localparam logic [addrBits-1:0] LAST_IDX = addrBits'(DEPTH - 1);
  localparam bit FULL_MAP = (DEPTH == (1 << addrBits));
  localparam logic [bitwidth-1:0] W_MAX = {1'b0, {(bitwidth-1){1'b1}}};
  localparam logic [bitwidth-1:0] W_MIN = {1'b1, {(bitwidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [addrBits-1:0]        idx;
  logic signed [bitwidth-1:0] grad_l;
  logic [bitwidth-1:0]        w_mem [DEPTH];

  logic grad_acc;
  logic beat;
  logic last_beat;
  logic ld_ok;
  logic rd_ok;

  logic signed [PW-1:0]   grad_ext;
  logic signed [PW-1:0]   x_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;
  logic [bitwidth-1:0]    d_sat;
  logic [bitwidth-1:0]    w_cur;
  logic [bitwidth:0]      diff;
  logic [bitwidth-1:0]    w_new;

  // Handshake outputs are pure state decodes so they track the FSM exactly.
  assign grad_ready = (state == IDLE);
  assign x_ready    = (state == UPDATE);
  assign busy       = (state == UPDATE);
  assign done       = (state == DONE);

  assign grad_acc  = grad_valid & grad_ready;
  assign beat      = x_valid & x_ready;
  assign last_beat = beat & (idx == LAST_IDX);

  // Address range qualification only costs logic when DEPTH leaves holes.
  generate
    if (FULL_MAP) begin : g_full_map
      assign ld_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part_map
      assign ld_ok = (32'(w_ld_addr) < 32'(DEPTH));
      assign rd_ok = (32'(w_rd_addr) < 32'(DEPTH));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grad_acc)  state_nxt = UPDATE;
      UPDATE:  if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Full-width signed product of latched gradient and current feature element.
  assign grad_ext = PW'(grad_l);
  assign x_ext    = PW'($signed(x_data));
  assign prod     = grad_ext * x_ext;
  assign shifted  = prod >>> fracBits;

  // Clamp the scaled delta into the weight range: it fits only when all bits
  // above the weight sign bit replicate that sign bit.
  always_comb begin
    d_sat = shifted[bitwidth-1:0];
    if (shifted[PW-1:bitwidth-1] != {(inputBitwidth+1){shifted[bitwidth-1]}}) begin
      d_sat = shifted[PW-1] ? W_MIN : W_MAX;
    end
  end

  // Saturating subtract using one guard bit to detect overflow.
  assign w_cur = w_mem[idx];
  assign diff  = {w_cur[bitwidth-1], w_cur} - {d_sat[bitwidth-1], d_sat};

  always_comb begin
    w_new = diff[bitwidth-1:0];
    if (diff[bitwidth] != diff[bitwidth-1]) begin
      w_new = diff[bitwidth] ? W_MIN : W_MAX;
    end
  end

  // Gradient latch and element index.
  always_ff @(posedge clk) begin
    if (rst) begin
      grad_l <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grad_acc) begin
            grad_l <= grad;
            idx    <= '0;
          end
        end
        UPDATE: begin
          if (beat) begin
            idx <= last_beat ? '0 : idx + addrBits'(1);
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

  // Weight register file: updates in UPDATE, external loads only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_mem[i] <= '0;
      end
    end else if (state == UPDATE) begin
      if (beat) begin
        w_mem[idx] <= w_new;
      end
    end else if (state == IDLE) begin
      if (w_ld_en && ld_ok) begin
        w_mem[w_ld_addr] <= w_ld_data;
      end
    end
  end

  // Registered read port; sees the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_rd_data <= '0;
    end else if (rd_ok) begin
      w_rd_data <= w_mem[w_rd_addr];
    end else begin
      w_rd_data <= '0;
    end
  end

  // Completed-sample counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (state == DONE) begin
      sample_cnt <= sample_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_weight_update_stage.sv
// Bench for weight_update_stage (DEPTH=4): directed cases plus randomized
// samples checked against an arithmetic reference model via scoreboards.
module tb_weight_update_stage;

  localparam int BW = 32;
  localparam int IW = 16;
  localparam int D  = 4;
  localparam int FB = 8;
  localparam int AB = 2;

  localparam longint MAXW = (64'sd1 <<< 31) - 1;
  localparam longint MINW = -(64'sd1 <<< 31);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] grad = '0;
  logic          grad_valid = 1'b0;
  logic          grad_ready;
  logic [IW-1:0] x_data = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic          w_ld_en = 1'b0;
  logic [AB-1:0] w_ld_addr = '0;
  logic [BW-1:0] w_ld_data = '0;
  logic [AB-1:0] w_rd_addr = '0;
  logic [BW-1:0] w_rd_data;
  logic          busy;
  logic          done;
  logic [15:0]   sample_cnt;

  always #5 clk = ~clk;

  weight_update_stage #(
    .bitwidth(BW), .inputBitwidth(IW), .DEPTH(D), .fracBits(FB), .addrBits(AB)
  ) dut (
    .clk(clk), .rst(rst),
    .grad(grad), .grad_valid(grad_valid), .grad_ready(grad_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .w_ld_en(w_ld_en), .w_ld_addr(w_ld_addr), .w_ld_data(w_ld_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  int checks = 0;
  int failures = 0;

  longint model_w [D];
  int     model_cnt = 0;
  longint xs [D];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } done_exp_t;

  done_exp_t     done_q [$];
  logic [BW-1:0] rd_q [$];
  logic          rd_req = 1'b0;
  logic          rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= rd_req;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MAXW) return MAXW;
    if (v < MINW) return MINW;
    return v;
  endfunction

  // Monitor: pops read and done expectations whenever the DUT presents them.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        check("rd_q_nonempty", rd_q.size(), 1);
      end else begin
        logic [BW-1:0] e;
        e = rd_q.pop_front();
        check("rd_data", longint'($signed(w_rd_data)), longint'($signed(e)));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        done_exp_t de;
        de = done_q.pop_front();
        check("done_cycle", cyc, de.cyc);
        check("done_cnt", sample_cnt, de.cnt);
        check("grad_ready_in_done", grad_ready, 0);
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    for (int i = 0; i < D; i++) model_w[i] = 0;
    model_cnt = 0;
  endtask

  task automatic load(input int a, input longint v);
    w_ld_en   = 1'b1;
    w_ld_addr = AB'(a);
    w_ld_data = v[BW-1:0];
    model_w[a] = v;
    tick();
    w_ld_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < D; a++) begin
      w_rd_addr = AB'(a);
      rd_req    = 1'b1;
      rd_q.push_back(model_w[a][BW-1:0]);
      tick();
    end
    rd_req = 1'b0;
    tick();
  endtask

  // One sample: offer gradient, then D beats from xs with optional stalls.
  task automatic run_sample(input longint g, input int stall_at, input int stall_len,
                            input int rand_max, input bit noise);
    int n;
    int acc;
    int stalls;
    grad = g[BW-1:0];
    grad_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!grad_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("grad_ready_accept", grad_ready, 1);
    if (!grad_ready) begin
      grad_valid = 1'b0;
      return;
    end
    acc = cyc;
    tick();
    grad_valid = 1'b0;
    stalls = 0;
    for (int i = 0; i < D; i++) begin
      int s;
      s = (i == stall_at) ? stall_len : 0;
      if (rand_max > 0) s += $urandom_range(0, rand_max);
      for (int k = 0; k < s; k++) begin
        x_valid = 1'b0;
        if (noise) begin
          grad_valid = 1'b1;
          grad       = 32'd999;
          w_ld_en    = 1'b1;
          w_ld_addr  = AB'($urandom_range(0, D - 1));
          w_ld_data  = $urandom();
        end
        @(negedge clk);
        check("busy_stall", busy, 1);
        tick();
        grad_valid = 1'b0;
        w_ld_en    = 1'b0;
      end
      stalls += s;
      x_valid = 1'b1;
      x_data  = xs[i][IW-1:0];
      n = 0;
      @(negedge clk);
      while (!x_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("x_ready_beat", x_ready, 1);
      if (!x_ready) begin
        x_valid = 1'b0;
        return;
      end
      model_w[i] = sat(model_w[i] - sat((g * xs[i]) >>> FB));
      if (i == D - 1) begin
        done_q.push_back('{cyc: acc + D + 1 + stalls, cnt: model_cnt});
        model_cnt = (model_cnt + 1) & 16'hFFFF;
      end
      tick();
      x_valid = 1'b0;
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    do_reset(2);
    check("reset_grad_ready", grad_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_x_ready", x_ready, 0);
    check("reset_sample_cnt", sample_cnt, 0);
    read_all();

    // Basic update, no stalls.
    load(0, 256); load(1, 512); load(2, -256); load(3, 0);
    for (int i = 0; i < D; i++) xs[i] = 256;
    run_sample(256, -1, 0, 0, 1'b0);
    read_all();
    check("basic_sample_cnt", sample_cnt, 1);

    // Same sample with a 3-cycle stall between beats 1 and 2.
    load(0, 256); load(1, 512); load(2, -256); load(3, 0);
    run_sample(256, 1, 3, 0, 1'b0);
    read_all();
    check("stall_sample_cnt", sample_cnt, 2);

    // Positive and negative saturation.
    load(0, 64'sh7FFFFF00);
    xs[0] = 256; xs[1] = 0; xs[2] = 0; xs[3] = 0;
    run_sample(-65536, -1, 0, 0, 1'b0);
    load(1, longint'($signed(32'h80000100)));
    xs[0] = 0; xs[1] = 256;
    run_sample(65536, -1, 0, 0, 1'b0);
    read_all();

    // Gradient and load strobes during UPDATE are ignored.
    load(0, 1000); load(1, -2000); load(2, 3000); load(3, 4);
    xs[0] = 100; xs[1] = -300; xs[2] = 77; xs[3] = -1;
    run_sample(5000, 0, 2, 2, 1'b1);
    read_all();

    // Reset after two accepted beats: abort, no done pulse.
    grad = 32'd1234;
    grad_valid = 1'b1;
    @(negedge clk);
    check("midrst_grad_ready", grad_ready, 1);
    tick();
    grad_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x_data  = 16'd500;
      tick();
    end
    x_valid = 1'b0;
    do_reset(1);
    check("midrst_grad_ready_after", grad_ready, 1);
    check("midrst_busy_after", busy, 0);
    check("midrst_sample_cnt", sample_cnt, 0);
    repeat (D + 2) tick();
    read_all();

    // Randomized samples.
    for (int it = 0; it < 25; it++) begin
      longint g;
      int nl;
      nl = $urandom_range(0, D);
      for (int k = 0; k < nl; k++)
        load($urandom_range(0, D - 1), longint'($signed($urandom())));
      if ($urandom_range(0, 1) == 1)
        g = longint'($signed($urandom()));
      else
        g = longint'($urandom_range(0, 200000)) - 100000;
      for (int i = 0; i < D; i++) xs[i] = longint'($signed(16'($urandom())));
      run_sample(g, -1, 0, 2, 1'($urandom_range(0, 1)));
      read_all();
    end
    check("final_sample_cnt", sample_cnt, model_cnt);

    repeat (3) tick();
    check("done_q_drained", done_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
